// File: rtl/branch_cond_gen.sv
// MIPS branch-condition generator: decodes the branch kind and produces zero/sign
// flags for the resolver through a two-stage valid/ready pipeline.
module branch_cond_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rt_field,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  branch,
  output logic        zero,
  output logic        sign,
  output logic [15:0] br_count
);

  localparam int unsigned OP_W    = 6;
  localparam int unsigned RT_W    = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CODE_W  = 3;
  localparam int unsigned COUNT_W = 16;

  localparam logic [OP_W-1:0] OP_REGIMM = OP_W'(1);
  localparam logic [OP_W-1:0] OP_BEQ    = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BNE    = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BLEZ   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BGTZ   = OP_W'(7);

  localparam logic [CODE_W-1:0] C_NONE = CODE_W'(0);
  localparam logic [CODE_W-1:0] C_BEQ  = CODE_W'(1);
  localparam logic [CODE_W-1:0] C_BNE  = CODE_W'(2);
  localparam logic [CODE_W-1:0] C_BGEZ = CODE_W'(3);
  localparam logic [CODE_W-1:0] C_BGTZ = CODE_W'(4);
  localparam logic [CODE_W-1:0] C_BLEZ = CODE_W'(5);
  localparam logic [CODE_W-1:0] C_BLTZ = CODE_W'(6);

  logic                s1_valid;
  logic [CODE_W-1:0]   s1_code;
  logic [DATA_W-1:0]   s1_rs;
  logic [DATA_W-1:0]   s1_rt;

  logic [CODE_W-1:0]   dec_code_c;
  logic [DATA_W-1:0]   diff_c;
  logic                zero_c;
  logic                sign_c;
  logic                s2_load_c;
  logic                accept_c;
  logic                consume_c;

  // Opcode / REGIMM decode of the incoming request
  always_comb begin
    dec_code_c = C_NONE;
    case (opcode)
      OP_BEQ:  dec_code_c = C_BEQ;
      OP_BNE:  dec_code_c = C_BNE;
      OP_BGTZ: dec_code_c = C_BGTZ;
      OP_BLEZ: dec_code_c = C_BLEZ;
      OP_REGIMM: begin
        if (rt_field == RT_W'(1))      dec_code_c = C_BGEZ;
        else if (rt_field == RT_W'(0)) dec_code_c = C_BLTZ;
        else                           dec_code_c = C_NONE;
      end
      default: dec_code_c = C_NONE;
    endcase
  end

  // Flags from the S1 operands: compare branches use rs-rt, the rest use rs alone
  always_comb begin
    diff_c = s1_rs - s1_rt;
    zero_c = 1'b0;
    sign_c = 1'b0;
    case (s1_code)
      C_BEQ, C_BNE: begin
        zero_c = (diff_c == '0);
        sign_c = 1'b0;
      end
      C_BGEZ, C_BGTZ, C_BLEZ, C_BLTZ: begin
        zero_c = (s1_rs == '0);
        sign_c = s1_rs[DATA_W-1];
      end
      default: begin
        zero_c = 1'b0;
        sign_c = 1'b0;
      end
    endcase
  end

  assign s2_load_c = !out_valid || out_ready;
  assign in_ready  = flush || !s1_valid || s2_load_c;
  assign accept_c  = in_valid && in_ready && !flush;
  assign consume_c = out_valid && out_ready;

  // Pipeline stages; flush empties both stages but a coincident consume still counts
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_code   <= C_NONE;
      s1_rs     <= '0;
      s1_rt     <= '0;
      out_valid <= 1'b0;
      branch    <= C_NONE;
      zero      <= 1'b0;
      sign      <= 1'b0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s2_load_c) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          branch <= s1_code;
          zero   <= zero_c;
          sign   <= sign_c;
        end
      end
      if (in_ready) begin
        s1_valid <= accept_c;
        if (accept_c) begin
          s1_code <= dec_code_c;
          s1_rs   <= rs_val;
          s1_rt   <= rt_val;
        end
      end
    end
  end

  // Saturating count of consumed results that are real branches
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count <= '0;
    end else if (consume_c && (branch != C_NONE) && (br_count != {COUNT_W{1'b1}})) begin
      br_count <= br_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_cond_gen.sv
// Bench for branch_cond_gen: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based reference model.
module tb_branch_cond_gen;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [4:0]  rt_field;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  branch;
  logic        zero;
  logic        sign;
  logic [15:0] br_count;

  int tests;
  int fails;
  bit chk_en;

  branch_cond_gen dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rt_field(rt_field), .rs_val(rs_val), .rt_val(rt_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .branch(branch), .zero(zero), .sign(sign), .br_count(br_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every request in flight is one queue entry, in order.
  typedef struct {
    int unsigned acc;
    logic [2:0]  code;
    logic        z;
    logic        s;
  } item_t;

  item_t       q[$];
  int unsigned ecnt;
  logic [15:0] mcnt;

  function automatic void ref_result(input logic [5:0] op, input logic [4:0] rtf,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [2:0] c, output logic z, output logic s);
    logic [31:0] d;
    d = a - b;
    if (op == 6'd4)                    c = 3'd1;
    else if (op == 6'd5)               c = 3'd2;
    else if (op == 6'd1 && rtf == 5'd1) c = 3'd3;
    else if (op == 6'd7)               c = 3'd4;
    else if (op == 6'd6)               c = 3'd5;
    else if (op == 6'd1 && rtf == 5'd0) c = 3'd6;
    else                               c = 3'd0;
    if (c == 3'd1 || c == 3'd2) begin
      z = (d == 32'd0);
      s = 1'b0;
    end else if (c != 3'd0) begin
      z = (a == 32'd0);
      s = a[31];
    end else begin
      z = 1'b0;
      s = 1'b0;
    end
  endfunction

  // An entry is visible at the output once one further edge has passed since it was taken
  function automatic bit m_vis();
    return (q.size() > 0) && (q[0].acc < ecnt);
  endfunction

  function automatic bit m_rdy();
    int waiting;
    waiting = q.size() - (m_vis() ? 1 : 0);
    return flush || (waiting == 0) || !m_vis() || out_ready;
  endfunction

  always @(posedge clk) begin
    item_t it;
    bit v;
    bit r;
    if (rst) begin
      q.delete();
      mcnt = 16'd0;
    end else begin
      v = m_vis();
      r = m_rdy();
      if (v && out_ready) begin
        if (q[0].code != 3'd0 && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
        void'(q.pop_front());
      end
      if (flush) begin
        q.delete();
      end else if (in_valid && r) begin
        ref_result(opcode, rt_field, rs_val, rt_val, it.code, it.z, it.s);
        it.acc = ecnt + 1;
        q.push_back(it);
      end
    end
    ecnt = ecnt + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_out_valid", 32'(out_valid), 32'(m_vis()));
      check("m_in_ready", 32'(in_ready), 32'(m_rdy()));
      check("m_br_count", 32'(br_count), 32'(mcnt));
      if (m_vis()) begin
        check("m_branch", 32'(branch), 32'(q[0].code));
        check("m_zero", 32'(zero), 32'(q[0].z));
        check("m_sign", 32'(sign), 32'(q[0].s));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [5:0] op, input logic [4:0] rtf,
                     input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    opcode   = op;
    rt_field = rtf;
    rs_val   = a;
    rt_val   = b;
  endtask

  initial begin
    logic [31:0] pick;
    tests = 0; fails = 0; chk_en = 1'b0; ecnt = 0; mcnt = 16'd0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = 6'd0; rt_field = 5'd0; rs_val = 32'd0; rt_val = 32'd0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_branch", 32'(branch), 32'd0);
    check("rst_br_count", 32'(br_count), 32'd0);

    // beq 5,5
    req(6'd4, 5'd0, 32'd5, 32'd5);
    step();
    in_valid = 1'b0;
    step();
    check("beq_valid", 32'(out_valid), 32'd1);
    check("beq_branch", 32'(branch), 32'd1);
    check("beq_zero", 32'(zero), 32'd1);
    check("beq_sign", 32'(sign), 32'd0);
    step();
    check("beq_count", 32'(br_count), 32'd1);

    // bltz then bgtz back to back
    req(6'd1, 5'd0, 32'h8000_0000, 32'd0);
    step();
    req(6'd7, 5'd0, 32'd0, 32'd0);
    step();
    in_valid = 1'b0;
    check("bltz_branch", 32'(branch), 32'd6);
    check("bltz_zs", 32'({zero, sign}), 32'b01);
    step();
    check("bgtz_valid", 32'(out_valid), 32'd1);
    check("bgtz_branch", 32'(branch), 32'd4);
    check("bgtz_zs", 32'({zero, sign}), 32'b10);
    step();

    // backpressure with three requests
    out_ready = 1'b0;
    req(6'd4, 5'd0, 32'd1, 32'd2);
    step();
    req(6'd5, 5'd0, 32'd3, 32'd3);
    step();
    req(6'd6, 5'd0, 32'd0, 32'd9);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    step();
    step();
    check("bp_stall_valid", 32'(out_valid), 32'd1);
    check("bp_stall_branch", 32'(branch), 32'd1);
    check("bp_stall_zero", 32'(zero), 32'd0);
    check("bp_stall_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("bp_second", 32'(branch), 32'd2);
    check("bp_second_zero", 32'(zero), 32'd1);
    step();
    check("bp_third", 32'(branch), 32'd5);
    check("bp_third_zs", 32'({zero, sign}), 32'b10);
    step();
    check("bp_drained", 32'(out_valid), 32'd0);

    // R-type does not branch
    req(6'd0, 5'd3, 32'd7, 32'd9);
    step();
    in_valid = 1'b0;
    step();
    check("rtype_branch", 32'(branch), 32'd0);
    check("rtype_zs", 32'({zero, sign}), 32'b00);
    step();
    check("rtype_count", 32'(br_count), 32'd6);

    // flush with both stages full plus a new request
    out_ready = 1'b0;
    req(6'd4, 5'd0, 32'd1, 32'd1);
    step();
    req(6'd5, 5'd0, 32'd1, 32'd2);
    step();
    req(6'd7, 5'd0, 32'd4, 32'd0);
    flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_s1_empty", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    step();
    step();
    check("flush_no_output", 32'(out_valid), 32'd0);
    check("flush_count", 32'(br_count), 32'd6);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      pick = $urandom_range(0, 7);
      in_valid = ($urandom_range(0, 3) != 0);
      case (pick)
        0: opcode = 6'd4;
        1: opcode = 6'd5;
        2: opcode = 6'd7;
        3: opcode = 6'd6;
        4, 5: opcode = 6'd1;
        6: opcode = 6'd0;
        default: opcode = 6'($urandom);
      endcase
      rt_field = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rs_val = 32'd0;
        1: rs_val = 32'h8000_0000 | 32'($urandom_range(0, 3));
        default: rs_val = $urandom;
      endcase
      rt_val    = ($urandom_range(0, 2) == 0) ? rs_val : $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    step();
    rst = 1'b0;
    check("pre_sat_count", 32'(br_count), 32'd0);

    // saturate the branch counter
    out_ready = 1'b1;
    req(6'd4, 5'd0, 32'd1, 32'd1);
    repeat (65537) step();
    in_valid = 1'b0;
    repeat (3) step();
    check("sat_count", 32'(br_count), 32'hFFFF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("sat_rst_count", 32'(br_count), 32'd0);
    check("sat_rst_valid", 32'(out_valid), 32'd0);
    check("sat_rst_flags", 32'({branch, zero, sign}), 32'd0);
    check("sat_rst_ready", 32'(in_ready), 32'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
